// File: rtl/cpu_decode.sv
// RV32I decode stage: fetch handshake in, registered decoded bundle out, 2-entry skid.
// Define CPU_DECODE_ILLEGAL_EN to enable the illegal-encoding check on d_illegal.
module cpu_decode #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] BUBBLE_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            f_vld,
  input  logic [31:0]     f_instr,
  input  logic [XLEN-1:0] f_pc,
  output logic            d_acc,
  input  logic            e_j_flag,
  input  logic            e_acc,
  output logic            d_vld,
  output logic [31:0]     d_instr,
  output logic [XLEN-1:0] d_pc,
  output logic [6:0]      d_opcode,
  output logic [4:0]      d_rd,
  output logic [4:0]      d_rs1,
  output logic [4:0]      d_rs2,
  output logic [2:0]      d_funct3,
  output logic [6:0]      d_funct7,
  output logic [XLEN-1:0] d_imm,
  output logic [2:0]      d_fmt,
  output logic            d_illegal
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_N = 3'd6;

  function automatic ent_t dec(input logic [31:0] i,
                               input logic [XLEN-1:0] pc);
    ent_t e;
    e.instr = i;
    e.pc    = pc;
    e.imm   = '0;
    e.ill   = 1'b0;
    case (i[6:0])
      7'b0110011: e.fmt = FMT_R;
      7'b0010011,
      7'b0000011,
      7'b1100111,
      7'b1110011,
      7'b0001111: e.fmt = FMT_I;
      7'b0100011: e.fmt = FMT_S;
      7'b1100011: e.fmt = FMT_B;
      7'b0110111,
      7'b0010111: e.fmt = FMT_U;
      7'b1101111: e.fmt = FMT_J;
      default:    e.fmt = FMT_N;
    endcase
    case (e.fmt)
      FMT_I: e.imm = {{20{i[31]}}, i[31:20]};
      FMT_S: e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B: e.imm = {{19{i[31]}}, i[31], i[7],
                      i[30:25], i[11:8], 1'b0};
      FMT_U: e.imm = {i[31:12], 12'b0};
      FMT_J: e.imm = {{11{i[31]}}, i[31], i[19:12],
                      i[20], i[30:21], 1'b0};
      default: e.imm = '0;
    endcase
`ifdef CPU_DECODE_ILLEGAL_EN
    e.ill = (i[1:0] != 2'b11) || (e.fmt == FMT_N)
         || ((i[6:0] == 7'b0110011)
             && (i[31:25] != 7'b0000000)
             && (i[31:25] != 7'b0100000))
         || ((i[6:0] == 7'b0000011)
             && ((i[14:12] == 3'b011)
                 || (i[14:12] == 3'b110)
                 || (i[14:12] == 3'b111)))
         || ((i[6:0] == 7'b0100011) && (i[14:12] > 3'b010))
         || ((i[6:0] == 7'b1100011)
             && ((i[14:12] == 3'b010)
                 || (i[14:12] == 3'b011)));
`endif
    return e;
  endfunction

  state_t state, nxt;
  ent_t   out_q, skid_q, dec_in, bub;
  logic   xin, xout;

  assign bub    = dec(BUBBLE_INSTR, '0);
  assign dec_in = dec(f_instr, f_pc);

  assign d_acc = (state != FULL);
  assign d_vld = (state != EMPTY);
  assign xin   = f_vld & d_acc;
  assign xout  = d_vld & e_acc;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (e_j_flag) begin
      nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (xin) nxt = ONE;
        ONE: begin
          if (xin && !xout)      nxt = FULL;
          else if (xout && !xin) nxt = EMPTY;
        end
        FULL: if (xout) nxt = ONE;
        default: nxt = EMPTY;
      endcase
    end
  end

  // Output register holds the bubble whenever no entry is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= bub;
      skid_q <= bub;
    end else if (e_j_flag) begin
      out_q <= bub;
    end else begin
      unique case (state)
        EMPTY: if (xin) out_q <= dec_in;
        ONE: begin
          if (xin && xout) out_q  <= dec_in;
          else if (xin)    skid_q <= dec_in;
          else if (xout)   out_q  <= bub;
        end
        FULL: if (xout) out_q <= skid_q;
        default: out_q <= bub;
      endcase
    end
  end

  assign d_instr   = out_q.instr;
  assign d_pc      = out_q.pc;
  assign d_opcode  = out_q.instr[6:0];
  assign d_rd      = out_q.instr[11:7];
  assign d_funct3  = out_q.instr[14:12];
  assign d_rs1     = out_q.instr[19:15];
  assign d_rs2     = out_q.instr[24:20];
  assign d_funct7  = out_q.instr[31:25];
  assign d_imm     = out_q.imm;
  assign d_fmt     = out_q.fmt;
  assign d_illegal = out_q.ill;

endmodule

// File: tb/tb_cpu_decode.sv
// Directed bench for cpu_decode: decode table, backpressure,
// flush and reset-while-full sequences.
module tb_cpu_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_vld;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        d_acc;
  logic        e_j_flag;
  logic        e_acc;
  logic        d_vld;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [6:0]  d_opcode;
  logic [4:0]  d_rd;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [2:0]  d_funct3;
  logic [6:0]  d_funct7;
  logic [31:0] d_imm;
  logic [2:0]  d_fmt;
  logic        d_illegal;

  int total = 0;
  int bad   = 0;
  logic [31:0] seen[$];

  cpu_decode dut (
    .clk(clk), .rst(rst),
    .f_vld(f_vld), .f_instr(f_instr), .f_pc(f_pc),
    .d_acc(d_acc), .e_j_flag(e_j_flag), .e_acc(e_acc),
    .d_vld(d_vld), .d_instr(d_instr), .d_pc(d_pc),
    .d_opcode(d_opcode), .d_rd(d_rd), .d_rs1(d_rs1),
    .d_rs2(d_rs2), .d_funct3(d_funct3), .d_funct7(d_funct7),
    .d_imm(d_imm), .d_fmt(d_fmt), .d_illegal(d_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t v[14];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  // Called just after a negedge; records an out-transfer, then advances.
  task automatic cyc();
    if (d_vld && e_acc) seen.push_back(d_pc);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  logic exp_ill;

  initial begin
    v[0]  = '{32'h00500093, 7'h13, 5'd1,  5'd0,  5'd5,  3'd0, 7'h00, 32'h00000005, 3'd1, 1'b0};
    v[1]  = '{32'hFFC0A103, 7'h03, 5'd2,  5'd1,  5'd28, 3'd2, 7'h7F, 32'hFFFFFFFC, 3'd1, 1'b0};
    v[2]  = '{32'h0020A423, 7'h23, 5'd8,  5'd1,  5'd2,  3'd2, 7'h00, 32'h00000008, 3'd2, 1'b0};
    v[3]  = '{32'hFE000CE3, 7'h63, 5'd25, 5'd0,  5'd0,  3'd0, 7'h7F, 32'hFFFFFFF8, 3'd3, 1'b0};
    v[4]  = '{32'h123452B7, 7'h37, 5'd5,  5'd8,  5'd3,  3'd5, 7'h09, 32'h12345000, 3'd4, 1'b0};
    v[5]  = '{32'h010000EF, 7'h6F, 5'd1,  5'd0,  5'd16, 3'd0, 7'h00, 32'h00000010, 3'd5, 1'b0};
    v[6]  = '{32'hFFFFFFFF, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h00000000, 3'd6, 1'b1};
    v[7]  = '{32'h00000000, 7'h00, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 3'd6, 1'b1};
    v[8]  = '{32'h402081B3, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 32'h00000000, 3'd0, 1'b0};
    v[9]  = '{32'h02208033, 7'h33, 5'd0,  5'd1,  5'd2,  3'd0, 7'h01, 32'h00000000, 3'd0, 1'b1};
    v[10] = '{32'h0000B003, 7'h03, 5'd0,  5'd1,  5'd0,  3'd3, 7'h00, 32'h00000000, 3'd1, 1'b1};
    v[11] = '{32'h00002063, 7'h63, 5'd0,  5'd0,  5'd0,  3'd2, 7'h00, 32'h00000000, 3'd3, 1'b1};
    v[12] = '{32'h00003023, 7'h23, 5'd0,  5'd0,  5'd0,  3'd3, 7'h00, 32'h00000000, 3'd2, 1'b1};
    v[13] = '{32'h00001097, 7'h17, 5'd1,  5'd0,  5'd0,  3'd1, 7'h00, 32'h00001000, 3'd4, 1'b0};

    rst = 1'b1; f_vld = 1'b0; f_instr = '0; f_pc = '0;
    e_j_flag = 1'b0; e_acc = 1'b0;
    @(negedge clk);
    do_reset();

    chk("rst_vld",   {31'b0, d_vld},     32'd0);
    chk("rst_acc",   {31'b0, d_acc},     32'd1);
    chk("rst_instr", d_instr,            32'h00000013);
    chk("rst_pc",    d_pc,               32'd0);
    chk("rst_imm",   d_imm,              32'd0);
    chk("rst_fmt",   {29'b0, d_fmt},     32'd1);
    chk("rst_op",    {25'b0, d_opcode},  32'h13);
    chk("rst_ill",   {31'b0, d_illegal}, 32'd0);

    // Streamed decode table with e_acc high: one entry per cycle.
    e_acc = 1'b1;
    for (int i = 0; i < 14; i++) begin
      f_vld   = 1'b1;
      f_instr = v[i].instr;
      f_pc    = 32'h100 + 32'(i) * 4;
      cyc();
`ifdef CPU_DECODE_ILLEGAL_EN
      exp_ill = v[i].ill;
`else
      exp_ill = 1'b0;
`endif
      chk($sformatf("v%0d_vld", i),   {31'b0, d_vld},     32'd1);
      chk($sformatf("v%0d_instr", i), d_instr,            v[i].instr);
      chk($sformatf("v%0d_pc", i),    d_pc,               32'h100 + 32'(i) * 4);
      chk($sformatf("v%0d_op", i),    {25'b0, d_opcode},  {25'b0, v[i].op});
      chk($sformatf("v%0d_rd", i),    {27'b0, d_rd},      {27'b0, v[i].rd});
      chk($sformatf("v%0d_rs1", i),   {27'b0, d_rs1},     {27'b0, v[i].rs1});
      chk($sformatf("v%0d_rs2", i),   {27'b0, d_rs2},     {27'b0, v[i].rs2});
      chk($sformatf("v%0d_f3", i),    {29'b0, d_funct3},  {29'b0, v[i].f3});
      chk($sformatf("v%0d_f7", i),    {25'b0, d_funct7},  {25'b0, v[i].f7});
      chk($sformatf("v%0d_imm", i),   d_imm,              v[i].imm);
      chk($sformatf("v%0d_fmt", i),   {29'b0, d_fmt},     {29'b0, v[i].fmt});
      chk($sformatf("v%0d_ill", i),   {31'b0, d_illegal}, {31'b0, exp_ill});
    end
    f_vld = 1'b0;
    cyc();
    chk("drain_vld",   {31'b0, d_vld}, 32'd0);
    chk("drain_instr", d_instr,        32'h00000013);

    // Backpressure: pc 0,4,8 with exec stalled.
    seen.delete();
    e_acc = 1'b0;
    f_vld = 1'b1; f_instr = v[0].instr; f_pc = 32'h0;
    cyc();
    chk("bp_acc1", {31'b0, d_acc}, 32'd1);
    f_instr = v[2].instr; f_pc = 32'h4;
    cyc();
    chk("bp_full_acc", {31'b0, d_acc}, 32'd0);
    chk("bp_full_pc",  d_pc,           32'h0);
    f_instr = v[4].instr; f_pc = 32'h8;
    cyc();
    cyc();
    chk("bp_hold_pc",    d_pc,    32'h0);
    chk("bp_hold_instr", d_instr, v[0].instr);
    chk("bp_hold_acc",   {31'b0, d_acc}, 32'd0);
    e_acc = 1'b1;
    cyc();
    chk("bp_skid_pc", d_pc, 32'h4);
    chk("bp_skid_imm", d_imm, 32'h8);
    cyc();
    f_vld = 1'b0;
    chk("bp_last_pc", d_pc, 32'h8);
    cyc();
    cyc();
    chk("bp_n", seen.size(), 32'd3);
    for (int k = 0; k < 3 && k < seen.size(); k++)
      chk($sformatf("bp_ord%0d", k), seen[k], 32'(k) * 4);

    // Flush while FULL with a concurrent fetch.
    seen.delete();
    e_acc = 1'b0;
    f_vld = 1'b1; f_instr = v[0].instr; f_pc = 32'h20;
    cyc();
    f_pc = 32'h24;
    cyc();
    chk("fl_pre_acc", {31'b0, d_acc}, 32'd0);
    f_pc = 32'h28; e_j_flag = 1'b1;
    cyc();
    e_j_flag = 1'b0; f_vld = 1'b0;
    chk("fl_vld",   {31'b0, d_vld}, 32'd0);
    chk("fl_acc",   {31'b0, d_acc}, 32'd1);
    chk("fl_instr", d_instr,        32'h00000013);
    e_acc = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    chk("fl_none", seen.size(), 32'd0);
    chk("fl_idle", {31'b0, d_vld}, 32'd0);

    // Reset asserted while FULL.
    e_acc = 1'b0;
    f_vld = 1'b1; f_instr = v[5].instr; f_pc = 32'h40;
    cyc();
    f_pc = 32'h44;
    cyc();
    chk("rf_pre_acc", {31'b0, d_acc}, 32'd0);
    f_vld = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rf_vld",   {31'b0, d_vld}, 32'd0);
    chk("rf_acc",   {31'b0, d_acc}, 32'd1);
    chk("rf_pc",    d_pc,           32'd0);
    chk("rf_instr", d_instr,        32'h00000013);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
